// File: rtl/memoria_morse_tx.sv
// Morse character memory plus serialiser: streams the first N stored codes MSB first,
// each bit held TICK_DIV clocks, optionally looping until stopped.
module memoria_morse_tx #(
   parameter int CODE_W   = 27,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int TICK_DIV = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Wr_en,
   input  logic [ADDR_W-1:0] Wr_addr,
   input  logic [CODE_W-1:0] Wr_data,
   input  logic [ADDR_W:0]   Num_carac,
   input  logic              Start,
   input  logic              Repeat,
   input  logic              Stop,
   output logic              salida,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] Carac_idx
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BIT_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CODE_W - 1);
   localparam logic [ADDR_W:0]   DEPTH_N   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [CODE_W-1:0] mem [DEPTH];
   logic [CODE_W-1:0] shreg;
   logic [TICK_W-1:0] tick_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_inc;
   logic [ADDR_W:0]   n_lat;
   logic [ADDR_W:0]   n_clamp;
   logic              rep_done;
   logic              start_ok;
   logic              tick_end;
   logic              char_end;
   logic              last_char;

   assign n_clamp   = (Num_carac > DEPTH_N) ? DEPTH_N : Num_carac;
   assign start_ok  = Start && (n_clamp != '0);
   assign tick_end  = (tick_cnt == TICK_LAST);
   assign char_end  = tick_end && (bit_cnt == BIT_LAST);
   assign last_char = ({1'b0, idx} == (n_lat - 1'b1));
   assign idx_inc   = idx + 1'b1;

   // Writes land in any state; the shift register holds its own copy so in-flight bits are safe.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (Wr_en && ({1'b0, Wr_addr} < DEPTH_N)) begin
         mem[Wr_addr] <= Wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (Stop) begin
               state_next = IDLE;
            end else if (char_end && last_char && !Repeat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg    <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         idx      <= '0;
         n_lat    <= '0;
         rep_done <= 1'b0;
      end else begin
         rep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  shreg    <= mem[0];
                  n_lat    <= n_clamp;
                  idx      <= '0;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
               end
            end
            SHIFT: begin
               if (Stop) begin
                  shreg    <= '0;
                  idx      <= '0;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
               end else if (!tick_end) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end else begin
                  tick_cnt <= '0;
                  if (!char_end) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= shreg << 1;
                  end else begin
                     bit_cnt <= '0;
                     // End of a character: advance, wrap for looping, or finish the pass.
                     if (last_char) begin
                        idx <= '0;
                        if (Repeat) begin
                           shreg    <= mem[0];
                           rep_done <= 1'b1;
                        end else begin
                           shreg <= '0;
                        end
                     end else begin
                        idx   <= idx_inc;
                        shreg <= mem[idx_inc];
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      Busy      = (state == SHIFT);
      salida    = (state == SHIFT) && shreg[CODE_W-1];
      Done      = (state == DONE) || rep_done;
      Carac_idx = idx;
   end

endmodule

// File: tb/tb_memoria_morse_tx.sv
// Directed bench for memoria_morse_tx: a small instance (8-bit codes, 4 entries, 2 clocks/bit)
// and a default-size instance for the write-during-transmission case.
module tb_memoria_morse_tx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       Wr_en;
   logic [1:0] Wr_addr;
   logic [7:0] Wr_data;
   logic [2:0] Num_carac;
   logic       Start;
   logic       Repeat;
   logic       Stop;
   logic       salida;
   logic       Busy;
   logic       Done;
   logic [1:0] Carac_idx;

   logic        b_wr_en;
   logic [3:0]  b_wr_addr;
   logic [26:0] b_wr_data;
   logic [4:0]  b_num;
   logic        b_start;
   logic        b_salida;
   logic        b_busy;
   logic        b_done;
   logic [3:0]  b_idx;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  model [4];
   logic [15:0] a5_pat;
   logic [26:0] v1;
   logic [26:0] v2;

   always #5 CLK = ~CLK;

   memoria_morse_tx #(
      .CODE_W(8), .DEPTH(4), .ADDR_W(2), .TICK_DIV(2)
   ) u_dut (
      .CLK(CLK), .RST(RST), .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
      .Num_carac(Num_carac), .Start(Start), .Repeat(Repeat), .Stop(Stop),
      .salida(salida), .Busy(Busy), .Done(Done), .Carac_idx(Carac_idx)
   );

   memoria_morse_tx #(
      .CODE_W(27), .DEPTH(16), .ADDR_W(4), .TICK_DIV(1)
   ) u_big (
      .CLK(CLK), .RST(RST), .Wr_en(b_wr_en), .Wr_addr(b_wr_addr), .Wr_data(b_wr_data),
      .Num_carac(b_num), .Start(b_start), .Repeat(1'b0), .Stop(1'b0),
      .salida(b_salida), .Busy(b_busy), .Done(b_done), .Carac_idx(b_idx)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
      Wr_en   = 1'b1;
      Wr_addr = addr;
      Wr_data = data;
      tick();
      Wr_en   = 1'b0;
      model[addr] = data;
   endtask

   task automatic startPass(input logic [2:0] n);
      Num_carac = n;
      Start     = 1'b1;
      tick();
      Start     = 1'b0;
   endtask

   // Expects n characters from the model back to back, two cycles per bit.
   task automatic checkPass(input int n, input string tag, input bit done_first);
      for (int c = 0; c < n; c++) begin
         for (int b = 0; b < 8; b++) begin
            for (int t = 0; t < 2; t++) begin
               checkOutput({tag, "_bit"}, salida, model[c][7-b]);
               checkOutput({tag, "_busy"}, Busy, 1);
               checkOutput({tag, "_idx"}, Carac_idx, c);
               checkOutput({tag, "_done"}, Done, (done_first && c == 0 && b == 0 && t == 0));
               tick();
            end
         end
      end
   endtask

   task automatic checkIdle(input string tag, input logic exp_done);
      checkOutput({tag, "_salida"}, salida, 0);
      checkOutput({tag, "_busy"}, Busy, 0);
      checkOutput({tag, "_done"}, Done, exp_done);
      checkOutput({tag, "_idx"}, Carac_idx, 0);
   endtask

   initial begin
      RST = 1'b1; Wr_en = 1'b0; Wr_addr = '0; Wr_data = '0; Num_carac = '0;
      Start = 1'b0; Repeat = 1'b0; Stop = 1'b0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_num = '0; b_start = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      tick();
      tick();
      RST = 1'b0;
      tick();
      checkIdle("reset", 1'b0);
      checkOutput("reset_big_busy", b_busy, 0);

      // Single A5 character against a hand-written bit sequence.
      a5_pat = 16'hCC33;
      applyStimulus(2'd0, 8'hA5);
      startPass(3'd1);
      for (int i = 0; i < 16; i++) begin
         checkOutput("a5_bit", salida, a5_pat[15-i]);
         checkOutput("a5_busy", Busy, 1);
         tick();
      end
      checkIdle("a5_done", 1'b1);
      tick();
      checkIdle("a5_idle", 1'b0);

      // Three characters with no gap cycles.
      applyStimulus(2'd0, 8'hFF);
      applyStimulus(2'd1, 8'h00);
      applyStimulus(2'd2, 8'h81);
      startPass(3'd3);
      checkPass(3, "three", 1'b0);
      checkIdle("three_done", 1'b1);
      tick();

      // Looping mode: Done at each wrap, Busy stays high, then Stop mid-character.
      Repeat = 1'b1;
      startPass(3'd2);
      checkPass(2, "rep1", 1'b0);
      checkPass(2, "rep2", 1'b1);
      checkOutput("rep3_done", Done, 1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("pre_stop_salida", salida, 1);
      Stop = 1'b1;
      tick();
      Stop   = 1'b0;
      Repeat = 1'b0;
      checkIdle("stop", 1'b0);
      tick();
      checkIdle("stop_after", 1'b0);

      // Count clamped to DEPTH.
      applyStimulus(2'd0, 8'h96);
      applyStimulus(2'd3, 8'h3C);
      startPass(3'd7);
      checkPass(4, "clamp", 1'b0);
      checkIdle("clamp_done", 1'b1);
      tick();

      // Zero count is ignored.
      startPass(3'd0);
      checkIdle("zero_n", 1'b0);
      tick();
      checkIdle("zero_n2", 1'b0);

      // Start held and count changed mid-pass have no effect.
      startPass(3'd1);
      Start     = 1'b1;
      Num_carac = 3'd3;
      checkPass(1, "nostart", 1'b0);
      Start = 1'b0;
      checkIdle("nostart_done", 1'b1);
      tick();
      checkIdle("nostart_idle", 1'b0);

      // Reset mid-pass beats simultaneous write/start/stop and clears memory.
      startPass(3'd1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("pre_rst_busy", Busy, 1);
      RST = 1'b1; Wr_en = 1'b1; Wr_addr = 2'd1; Wr_data = 8'hFF; Start = 1'b1; Stop = 1'b1;
      tick();
      RST = 1'b0; Wr_en = 1'b0; Start = 1'b0; Stop = 1'b0;
      checkIdle("rst", 1'b0);
      for (int i = 0; i < 4; i++) model[i] = '0;
      startPass(3'd4);
      checkPass(4, "cleared", 1'b0);
      checkIdle("cleared_done", 1'b1);
      tick();

      // Rewriting entry 0 while it is being shifted out.
      v1 = 27'h4D2B3C1;
      v2 = 27'h1234567;
      b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = v1;
      tick();
      b_wr_en = 1'b0;
      b_num   = 5'd1;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 27; i++) begin
         checkOutput("big1_bit", b_salida, v1[26-i]);
         checkOutput("big1_busy", b_busy, 1);
         if (i == 10) begin
            b_wr_en = 1'b1; b_wr_data = v2;
         end else begin
            b_wr_en = 1'b0;
         end
         tick();
      end
      b_wr_en = 1'b0;
      checkOutput("big1_done", b_done, 1);
      checkOutput("big1_end_busy", b_busy, 0);
      tick();
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 27; i++) begin
         checkOutput("big2_bit", b_salida, v2[26-i]);
         checkOutput("big2_idx", b_idx, 0);
         tick();
      end
      checkOutput("big2_done", b_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memoria_morse_tx.md
MEMORIA_MORSE_TX -- requirements
Module: memoria_morse_tx

Interface
REQ-001 SHALL have parameter CODE_W, default 27: bits per stored character code.
REQ-002 SHALL have parameter DEPTH, default 16: number of character entries.
REQ-003 SHALL have parameter ADDR_W, default 4: entry address width; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter TICK_DIV, default 1: CLK cycles per transmitted bit, >= 1.
REQ-005 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port Wr_en  in  1  write strobe for the character memory.
REQ-008 SHALL have port Wr_addr  in  ADDR_W  entry written when Wr_en=1.
REQ-009 SHALL have port Wr_data  in  CODE_W  character code written.
REQ-010 SHALL have port Num_carac  in  ADDR_W+1  number of entries to send, starting at entry 0.
REQ-011 SHALL have port Start  in  1  level-sampled request to begin transmission.
REQ-012 SHALL have port Repeat  in  1  continuous (looping) mode select.
REQ-013 SHALL have port Stop  in  1  abort request.
REQ-014 SHALL have port salida  out  1  serial Morse bit stream.
REQ-015 SHALL have port Busy  out  1  high while bits are being shifted.
REQ-016 SHALL have port Done  out  1  one-cycle pulse at end of each pass.
REQ-017 SHALL have port Carac_idx  out  ADDR_W  index of entry currently being sent.

Function
REQ-018 Memory SHALL be DEPTH x CODE_W registers; Wr_en=1 with Wr_addr<DEPTH writes Wr_data at the next edge; Wr_addr>=DEPTH SHALL be ignored.
REQ-019 Writes SHALL be accepted in every state; a write to the entry currently held in the shift register SHALL NOT alter the bits in flight.
REQ-020 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-021 IDLE: Start=1 and clamped count N!=0 at edge k -> SHIFT at k+1, shift register loaded with entry 0, Carac_idx=0, Busy=1, salida=entry0[CODE_W-1].
REQ-022 N SHALL be Num_carac clamped to DEPTH, latched at Start; later Num_carac changes SHALL have no effect until the next Start.
REQ-023 Start with Num_carac=0 SHALL be ignored (stay IDLE, no Done).
REQ-024 Start SHALL be ignored in SHIFT and DONE.
REQ-025 salida SHALL be the shift register MSB; each bit held exactly TICK_DIV cycles, characters sent MSB first.
REQ-026 After bit 0 of an entry that is not the last, the next entry SHALL load with no gap cycle and Carac_idx SHALL increment.
REQ-027 After bit 0 of entry N-1 with Repeat=0: DONE for one cycle (Done=1, Busy=0, salida=0), then IDLE.
REQ-028 After bit 0 of entry N-1 with Repeat=1: stay SHIFT, reload entry 0 with no gap, Carac_idx=0, Done=1 for that one cycle, Busy stays 1.
REQ-029 A pass SHALL occupy exactly N*CODE_W*TICK_DIV cycles of Busy=1.
REQ-030 Stop=1 in SHIFT SHALL go to IDLE at the next edge: salida=0, Busy=0, Carac_idx=0, no Done pulse; Stop has priority over Repeat and end-of-pass.
REQ-031 In IDLE and DONE salida SHALL be 0.

Reset
REQ-032 RST=1 at an edge SHALL, from any state including mid-transmission: state IDLE, salida=0, Busy=0, Done=0, Carac_idx=0, bit/tick counters 0, all memory entries 0.
REQ-033 RST SHALL take priority over Wr_en, Start and Stop in the same cycle.

Verification (CODE_W=8, DEPTH=4, TICK_DIV=2 unless noted)
REQ-034 Write 8'hA5 to entry 0, Num_carac=1, Start pulse -> salida 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 over 16 cycles, Busy high 16 cycles, Done pulse next cycle, then IDLE.
REQ-035 Entries 0..2 = 8'hFF, 8'h00, 8'h81, Num_carac=3 -> 48 contiguous bit-cycles, Carac_idx 0->1->2 at 16-cycle boundaries, no gap cycles.
REQ-036 Repeat=1, Num_carac=2 -> Done pulses every 32 cycles with Busy continuously high; Stop asserted mid-char -> salida=0, Busy=0 next cycle, no Done.
REQ-037 Num_carac=7 -> clamped to 4 (64 Busy cycles); Num_carac=0 -> no activity; Start during Busy -> no restart.
REQ-038 RST asserted at cycle 5 of a pass -> all outputs at reset values next cycle; memory reads back 0 on subsequent Start (salida all 0).
REQ-039 TICK_DIV=1, CODE_W=27, DEPTH=16: write entry 0 during its own transmission -> in-flight bits unchanged, new value sent on next pass.
